pipe_stage_skid: RTL and testbench

- Parametrised successor to the fixed decode/execute stage register.
- Carries a generic control bundle plus data payload between two pipeline stages over a valid/ready handshake.
- Two-entry skid buffer gives full throughput with registered backpressure, plus synchronous flush (bubble injection).
- Instanced at every stage boundary: D->E, E->M, M->W.

---
 rtl/pipe_stage_skid_if.sv | 28 ++
 rtl/pipe_stage_skid.sv | 173 +++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between two pipeline stages: an upstream valid/ready
// request with control and payload, and a downstream head entry plus the
// stage occupancy. The master modport belongs to the agent that drives
// the stage, and the slave modport belongs to the stage itself.
interface pipe_stage_skid_if #(
   parameter int DATA_WIDTH = 96,
   parameter int CTRL_WIDTH = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [CTRL_WIDTH-1:0] in_ctrl;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [CTRL_WIDTH-1:0] out_ctrl;
   logic [DATA_WIDTH-1:0] out_data;
   logic [1:0]            occupancy;

   modport master (
      output in_valid, in_ctrl, in_data, out_ready,
      input  in_ready, out_valid, out_ctrl, out_data, occupancy
   );

   modport slave (
      input  in_valid, in_ctrl, in_data, out_ready,
      output in_ready, out_valid, out_ctrl, out_data, occupancy
   );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a two-entry skid buffer.
// The head entry sits in the main register and drives the outputs directly.
// The skid register catches one extra entry, so in_ready can be registered
// without losing throughput. CLR flushes the stage and leaves a bubble that
// reads as all zeros, which decodes as a NOP downstream.
// Optional feature: define PIPE_STAGE_SKID_PERF_EN to add the saturating
// stall, bubble and flush performance counters.
module pipe_stage_skid #(
   parameter int DATA_WIDTH = 96,
   parameter int CTRL_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 CLR,
`ifdef PIPE_STAGE_SKID_PERF_EN
   output logic [CNT_WIDTH-1:0] stall_cnt,
   output logic [CNT_WIDTH-1:0] bubble_cnt,
   output logic [CNT_WIDTH-1:0] flush_cnt,
`endif
   pipe_stage_skid_if.slave     bus
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL1 = 2'd1,
      ST_FULL2 = 2'd2
   } state_t;

   state_t                state_q;
   logic [CTRL_WIDTH-1:0] main_ctrl_q;
   logic [DATA_WIDTH-1:0] main_data_q;
   logic [CTRL_WIDTH-1:0] skid_ctrl_q;
   logic [DATA_WIDTH-1:0] skid_data_q;
   logic                  out_valid_q;
   logic                  in_ready_q;
   logic [1:0]            occ_q;
   logic                  acc_s;
   logic                  drn_s;

   assign acc_s = bus.in_valid & in_ready_q;
   assign drn_s = out_valid_q & bus.out_ready;

   // The outputs come straight from registers. main is kept at zero
   // whenever the stage is empty, so a bubble reads as zero.
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_ctrl  = main_ctrl_q;
   assign bus.out_data  = main_data_q;
   assign bus.occupancy = occ_q;

   // Skid FSM. A single block updates the state, both entry registers and
   // the registered handshake outputs.
   always_ff @(posedge CLK) begin
      if (!RST_N || CLR) begin
         state_q     <= ST_EMPTY;
         main_ctrl_q <= {CTRL_WIDTH{1'b0}};
         main_data_q <= {DATA_WIDTH{1'b0}};
         skid_ctrl_q <= {CTRL_WIDTH{1'b0}};
         skid_data_q <= {DATA_WIDTH{1'b0}};
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         occ_q       <= 2'd0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (acc_s) begin
                  state_q     <= ST_FULL1;
                  main_ctrl_q <= bus.in_ctrl;
                  main_data_q <= bus.in_data;
                  out_valid_q <= 1'b1;
                  in_ready_q  <= 1'b1;
                  occ_q       <= 2'd1;
               end else begin
                  state_q     <= ST_EMPTY;
               end
            end
            ST_FULL1: begin
               if (acc_s && drn_s) begin
                  // The head leaves and the new entry takes its place.
                  main_ctrl_q <= bus.in_ctrl;
                  main_data_q <= bus.in_data;
               end else if (acc_s) begin
                  // The head is blocked, so the new entry goes into the skid slot.
                  state_q     <= ST_FULL2;
                  skid_ctrl_q <= bus.in_ctrl;
                  skid_data_q <= bus.in_data;
                  in_ready_q  <= 1'b0;
                  occ_q       <= 2'd2;
               end else if (drn_s) begin
                  state_q     <= ST_EMPTY;
                  main_ctrl_q <= {CTRL_WIDTH{1'b0}};
                  main_data_q <= {DATA_WIDTH{1'b0}};
                  out_valid_q <= 1'b0;
                  occ_q       <= 2'd0;
               end else begin
                  state_q     <= ST_FULL1;
               end
            end
            ST_FULL2: begin
               if (drn_s) begin
                  // The skid entry moves into the head, and the skid slot is cleared.
                  state_q     <= ST_FULL1;
                  main_ctrl_q <= skid_ctrl_q;
                  main_data_q <= skid_data_q;
                  skid_ctrl_q <= {CTRL_WIDTH{1'b0}};
                  skid_data_q <= {DATA_WIDTH{1'b0}};
                  in_ready_q  <= 1'b1;
                  occ_q       <= 2'd1;
               end else begin
                  state_q     <= ST_FULL2;
               end
            end
            default: begin
               state_q     <= ST_EMPTY;
               main_ctrl_q <= {CTRL_WIDTH{1'b0}};
               main_data_q <= {DATA_WIDTH{1'b0}};
               skid_ctrl_q <= {CTRL_WIDTH{1'b0}};
               skid_data_q <= {DATA_WIDTH{1'b0}};
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               occ_q       <= 2'd0;
            end
         endcase
      end
   end

`ifdef PIPE_STAGE_SKID_PERF_EN
   logic [CNT_WIDTH-1:0] stall_cnt_q;
   logic [CNT_WIDTH-1:0] bubble_cnt_q;
   logic [CNT_WIDTH-1:0] flush_cnt_q;
   logic [CNT_WIDTH-1:0] stall_cnt_d;
   logic [CNT_WIDTH-1:0] bubble_cnt_d;
   logic [CNT_WIDTH-1:0] flush_cnt_d;

   // Adds one to a counter when en is set, and holds once it reaches all-ones.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                     input logic en);
      logic [CNT_WIDTH-1:0] r;
      if (en && (v != {CNT_WIDTH{1'b1}})) begin
         r = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         r = v;
      end
      return r;
   endfunction

   // Next counter values. CLR does not clear the counters.
   always_comb begin
      stall_cnt_d  = sat_inc(stall_cnt_q,  bus.in_valid & ~in_ready_q);
      bubble_cnt_d = sat_inc(bubble_cnt_q, bus.out_ready & ~out_valid_q);
      flush_cnt_d  = sat_inc(flush_cnt_q,  CLR);
   end

   // The counters are cleared only by reset.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         stall_cnt_q  <= {CNT_WIDTH{1'b0}};
         bubble_cnt_q <= {CNT_WIDTH{1'b0}};
         flush_cnt_q  <= {CNT_WIDTH{1'b0}};
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
   assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid.
// The reference model is a FIFO queue with a capacity of two. The queue is
// the expected-output scoreboard, and the monitor compares the DUT head
// against its front entry on every cycle.
module tb_pipe_stage_skid;
   localparam int DW = 96;
   localparam int CW = 16;
   localparam int NW = 4;

   typedef struct packed {
      logic [CW-1:0] ctrl;
      logic [DW-1:0] data;
   } entry_t;

   logic clk;
   logic rst_n;
   logic clr;
   int   errors = 0;
   int   checks = 0;
   entry_t exp_q[$];

   pipe_stage_skid_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

`ifdef PIPE_STAGE_SKID_PERF_EN
   logic [NW-1:0] stall_cnt, bubble_cnt, flush_cnt;
   int m_stall = 0, m_bubble = 0, m_flush = 0;
`endif

   pipe_stage_skid #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
      .CLK        (clk),
      .RST_N      (rst_n),
      .CLR        (clr),
`ifdef PIPE_STAGE_SKID_PERF_EN
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt),
      .flush_cnt  (flush_cnt),
`endif
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a FIFO with a capacity of two. The stage takes an
   // entry only when it held fewer than two at the start of the cycle.
   always @(posedge clk) begin
      int  sz;
      bit  acc, drn;
      if (!rst_n) begin
         exp_q.delete();
`ifdef PIPE_STAGE_SKID_PERF_EN
         m_stall = 0; m_bubble = 0; m_flush = 0;
`endif
      end else begin
         sz  = exp_q.size();
         acc = bus.in_valid && (sz < 2);
         drn = (sz > 0) && bus.out_ready;
`ifdef PIPE_STAGE_SKID_PERF_EN
         if (bus.in_valid && sz == 2 && m_stall < 15) m_stall++;
         if (bus.out_ready && sz == 0 && m_bubble < 15) m_bubble++;
         if (clr && m_flush < 15) m_flush++;
`endif
         if (clr) begin
            exp_q.delete();
         end else begin
            if (drn) void'(exp_q.pop_front());
            if (acc) exp_q.push_back('{ctrl: bus.in_ctrl, data: bus.in_data});
         end
      end
   end

   // Monitor: compares the outputs with the model away from the active clock edge.
   always @(negedge clk) begin
      entry_t head;
      int     sz;
      sz   = exp_q.size();
      head = (sz > 0) ? exp_q[0] : '0;
      chk("out_valid", {127'd0, bus.out_valid}, {127'd0, sz > 0});
      chk("out_ctrl",  {112'd0, bus.out_ctrl},  {112'd0, head.ctrl});
      chk("out_data",  {32'd0, bus.out_data},   {32'd0, head.data});
      chk("occupancy", {126'd0, bus.occupancy}, 128'(sz));
      chk("in_ready",  {127'd0, bus.in_ready},  {127'd0, sz < 2});
`ifdef PIPE_STAGE_SKID_PERF_EN
      chk("stall_cnt",  {124'd0, stall_cnt},  128'(m_stall));
      chk("bubble_cnt", {124'd0, bubble_cnt}, 128'(m_bubble));
      chk("flush_cnt",  {124'd0, flush_cnt},  128'(m_flush));
`endif
   end

   // Drives one cycle of stimulus and waits for the next negative edge.
   task automatic step(input bit v, input logic [CW-1:0] c, input bit ordy,
                       input bit fl, input bit rn);
      bus.in_valid  = v;
      bus.in_ctrl   = c;
      bus.in_data   = {$urandom, $urandom, $urandom};
      bus.out_ready = ordy;
      clr           = fl;
      rst_n         = rn;
      @(negedge clk);
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_ctrl = '0; bus.in_data = '0;
      bus.out_ready = 1'b0; clr = 1'b0; rst_n = 1'b0;
      // Reset for two cycles.
      @(negedge clk);
      step(0, 16'h0000, 0, 0, 0);
      // Stream with the downstream always ready.
      step(1, 16'h0001, 1, 0, 1);
      step(1, 16'h0002, 1, 0, 1);
      step(1, 16'h0003, 1, 0, 1);
      step(0, 16'h0000, 1, 0, 1);
      // Backpressure: C is held off until the buffer drains.
      step(1, 16'h00AA, 0, 0, 1);
      step(1, 16'h00BB, 0, 0, 1);
      step(1, 16'h00CC, 0, 0, 1);
      step(1, 16'h00CC, 0, 0, 1);
      step(1, 16'h00CC, 1, 0, 1);
      step(1, 16'h00CC, 1, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 16'h0000, 1, 0, 1);
      // Flush while full, with DD offered in the same cycle.
      step(1, 16'h00AA, 0, 0, 1);
      step(1, 16'h00BB, 0, 0, 1);
      step(1, 16'h00DD, 0, 1, 1);
      step(0, 16'h0000, 0, 0, 1);
      // Reset while full, then one push.
      step(1, 16'h00AA, 0, 0, 1);
      step(1, 16'h00BB, 0, 0, 1);
      step(0, 16'h0000, 0, 0, 0);
      step(1, 16'h0011, 0, 0, 1);
      step(0, 16'h0000, 1, 0, 1);
      // Bubble zeroing: the stage is empty while out_ready is high.
      step(0, 16'h0000, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 16'h0000, 1, 0, 1);
      // Long stall to saturate the stall counter, then a flush, then a reset.
      for (int i = 0; i < 22; i++) step(1, 16'h0042, 0, 0, 1);
      step(0, 16'h0000, 0, 1, 1);
      step(1, 16'h0043, 0, 0, 1);
      step(0, 16'h0000, 0, 0, 0);
      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(99) < 70, CW'($urandom), $urandom_range(99) < 60,
              $urandom_range(99) < 3, !($urandom_range(199) < 1));
      end
      step(0, 16'h0000, 1, 0, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
